// File: rtl/hdu_pkg.sv
// Shared definitions for the hazard detection unit.
//   sb_entry_t   : one scoreboard slot {valid, dst register, remaining latency}
//   JUMPOP_NONE  : EX_JumpOP value meaning "no taken branch/jump"
//   DEF_*        : default parameter values for the top level
// The entry fields are sized for the widest supported configuration;
// narrower register addresses and latencies are zero-extended into them.
package hdu_pkg;

  localparam int SB_REG_W = 8;
  localparam int SB_CNT_W = 8;

  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_BR_FLUSH = 1;

  localparam logic [1:0] JUMPOP_NONE = 2'b00;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] dst;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/hdu_sb_entry.sv
// One scoreboard slot tracking a load whose data is not yet forwardable.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_adv        : pipeline advances this edge (memory ready)
//   i_cap        : write a new load into this slot at this edge
//   i_cap_reg    : destination register of the captured load
//   i_rs, i_rt   : ID-stage source registers to compare against
//   o_valid      : slot holds a live load
//   o_free       : slot may be (re)used by a capture at this edge
//   o_dup        : slot already tracks i_cap_reg
//   o_hit_rs/rt  : slot register equals i_rs / i_rt
module hdu_sb_entry
  import hdu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_cap,
  input  logic [REG_AW-1:0] i_cap_reg,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  output logic              o_valid,
  output logic              o_free,
  output logic              o_dup,
  output logic              o_hit_rs,
  output logic              o_hit_rt
);

  sb_entry_t r_entry;
  logic      w_last;

  assign w_last = (r_entry.cnt == SB_CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
    end else if (i_adv) begin
      if (i_cap) begin
        r_entry.valid <= 1'b1;
        r_entry.dst   <= SB_REG_W'(i_cap_reg);
        r_entry.cnt   <= SB_CNT_W'(LOAD_LAT);
      end else if (r_entry.valid) begin
        if (w_last) begin
          r_entry <= '0;
        end else begin
          r_entry.cnt <= r_entry.cnt - SB_CNT_W'(1);
        end
      end
    end
  end

  assign o_valid  = r_entry.valid;
  // An entry expiring at this edge can take the new load in the same edge.
  assign o_free   = !r_entry.valid || w_last;
  assign o_dup    = r_entry.valid && (r_entry.dst == SB_REG_W'(i_cap_reg));
  assign o_hit_rs = r_entry.valid && (r_entry.dst == SB_REG_W'(i_rs));
  assign o_hit_rt = r_entry.valid && (r_entry.dst == SB_REG_W'(i_rt));

endmodule

// File: rtl/hdu_scoreboard.sv
// Hazard detection unit for the 5-stage pipeline with multi-cycle data memory.
// Combines the EX load-use check with a scoreboard of in-flight loads, a
// branch flush window, a memory-wait freeze and a stall statistics counter.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   ID_Rs/Rt, *Use      : ID-stage sources and whether they are read
//   EX_WR_out, EX_MemtoReg, EX_RegWrite : EX-stage destination / load info
//   EX_JumpOP           : non-zero = taken branch/jump resolved in EX
//   Mem_ready           : memory completes this cycle; 0 freezes everything
//   PCWrite, IF_IDWrite : front-end write enables
//   IF_Flush, ID_Flush  : squash IF/ID, bubble into ID/EX
//   Branch_Flush        : one-cycle pulse on a branch redirect
//   Load_wait           : memory-busy freeze
//   stall_cnt           : saturating count of load-use stall cycles
// Handshake: there is no valid/ready pair here; Mem_ready acts as a global
// advance qualifier - no state changes on an edge where it is low.
module hdu_scoreboard
  import hdu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int BR_FLUSH = DEF_BR_FLUSH,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_RsUse,
  input  logic              ID_RtUse,
  input  logic [REG_AW-1:0] EX_WR_out,
  input  logic              EX_MemtoReg,
  input  logic              EX_RegWrite,
  input  logic [1:0]        EX_JumpOP,
  input  logic              Mem_ready,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic              Branch_Flush,
  output logic              Load_wait,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int FW = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;

  logic                w_ex_load;
  logic                w_branch;
  logic                w_cap;
  logic [LOAD_LAT-1:0] w_valid;
  logic [LOAD_LAT-1:0] w_free;
  logic [LOAD_LAT-1:0] w_dup;
  logic [LOAD_LAT-1:0] w_hit_rs;
  logic [LOAD_LAT-1:0] w_hit_rt;
  logic [LOAD_LAT-1:0] w_sel;
  logic                w_slot_found;
  logic                w_rs_match;
  logic                w_rt_match;
  logic                w_hz;
  logic [FW-1:0]       r_flush_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_ex_load = EX_MemtoReg && EX_RegWrite && (EX_WR_out != '0);
  assign w_branch  = (EX_JumpOP != JUMPOP_NONE);
  assign w_cap     = w_ex_load && Mem_ready;

  // Slot choice: an entry already tracking the register wins (youngest load
  // replaces it); otherwise the lowest-index free slot.
  always_comb begin
    w_sel        = '0;
    w_slot_found = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (!w_slot_found && w_dup[i]) begin
        w_sel[i]     = 1'b1;
        w_slot_found = 1'b1;
      end
    end
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (!w_slot_found && w_free[i]) begin
        w_sel[i]     = 1'b1;
        w_slot_found = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LOAD_LAT; g++) begin : g_slot
    hdu_sb_entry #(
      .REG_AW   (REG_AW),
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst),
      .i_adv     (Mem_ready),
      .i_cap     (w_cap && w_sel[g]),
      .i_cap_reg (EX_WR_out),
      .i_rs      (ID_Rs),
      .i_rt      (ID_Rt),
      .o_valid   (w_valid[g]),
      .o_free    (w_free[g]),
      .o_dup     (w_dup[g]),
      .o_hit_rs  (w_hit_rs[g]),
      .o_hit_rt  (w_hit_rt[g])
    );
  end

  a_sb_capacity: assert property (@(posedge clk) disable iff (!rst)
    !(w_cap && !w_slot_found))
    else $error("hdu_scoreboard: load captured with no free scoreboard slot");

  assign w_rs_match = (ID_Rs != '0) &&
                      ((w_ex_load && (EX_WR_out == ID_Rs)) || (|w_hit_rs));
  assign w_rt_match = (ID_Rt != '0) &&
                      ((w_ex_load && (EX_WR_out == ID_Rt)) || (|w_hit_rt));
  assign w_hz       = (w_rs_match && ID_RsUse) || (w_rt_match && ID_RtUse);

  // Flush window: counts the extra IF_Flush cycles after the branch cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (Mem_ready) begin
      if (w_branch) begin
        r_flush_cnt <= FW'(BR_FLUSH - 1);
      end else if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_hz && !w_branch && Mem_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

  // Priority: reset, then memory wait, then branch, then load-use stall.
  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_Flush     = 1'b0;
    ID_Flush     = 1'b0;
    Branch_Flush = 1'b0;
    Load_wait    = 1'b0;
    if (rst) begin
      if (!Mem_ready) begin
        Load_wait  = 1'b1;
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
      end else if (w_branch) begin
        IF_Flush     = 1'b1;
        ID_Flush     = 1'b1;
        Branch_Flush = 1'b1;
      end else begin
        IF_Flush = (r_flush_cnt != '0);
        if (w_hz) begin
          PCWrite    = 1'b0;
          IF_IDWrite = 1'b0;
          ID_Flush   = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Self-checking bench for hdu_scoreboard (LOAD_LAT=2, BR_FLUSH=3).
// Reference model: per-register "cycles until forwardable" array plus a
// flush-cycles-remaining integer, evaluated from the behavioural rules.
module tb_hdu_scoreboard;

  localparam int LL = 2;
  localparam int BF = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  ID_Rs, ID_Rt, EX_WR_out;
  logic        ID_RsUse, ID_RtUse, EX_MemtoReg, EX_RegWrite, Mem_ready;
  logic [1:0]  EX_JumpOP;
  logic        PCWrite, IF_IDWrite, IF_Flush, ID_Flush, Branch_Flush, Load_wait;
  logic [15:0] stall_cnt;
  logic [5:0]  w_outs;

  assign w_outs = {PCWrite, IF_IDWrite, IF_Flush, ID_Flush, Branch_Flush, Load_wait};

  hdu_scoreboard #(
    .REG_AW   (5),
    .LOAD_LAT (LL),
    .BR_FLUSH (BF),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_RsUse     (ID_RsUse),
    .ID_RtUse     (ID_RtUse),
    .EX_WR_out    (EX_WR_out),
    .EX_MemtoReg  (EX_MemtoReg),
    .EX_RegWrite  (EX_RegWrite),
    .EX_JumpOP    (EX_JumpOP),
    .Mem_ready    (Mem_ready),
    .PCWrite      (PCWrite),
    .IF_IDWrite   (IF_IDWrite),
    .IF_Flush     (IF_Flush),
    .ID_Flush     (ID_Flush),
    .Branch_Flush (Branch_Flush),
    .Load_wait    (Load_wait),
    .stall_cnt    (stall_cnt)
  );

  // scoreboard / counters
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  // reference model state
  int pend[32];
  int flush_left;
  int exp_stall;

  // observed-event counters for directed scenarios
  int n_pc_low, n_if_fl, n_id_fl, n_br_fl, n_lw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_match(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (EX_MemtoReg && EX_RegWrite && (EX_WR_out == r)) || (pend[r] > 0);
  endfunction

  function automatic bit m_hz();
    return (m_match(ID_Rs) && ID_RsUse) || (m_match(ID_Rt) && ID_RtUse);
  endfunction

  function automatic logic [5:0] m_outs();
    bit hz;
    if (!rst)                 return 6'b110000;
    if (!Mem_ready)           return 6'b000001;
    if (EX_JumpOP != 2'b00)   return 6'b111110;
    hz = m_hz();
    return {!hz, !hz, (flush_left > 0), hz, 1'b0, 1'b0};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    flush_left = 0;
    exp_stall  = 0;
  endtask

  // Applies one clock edge's worth of rules to the model (inputs still held).
  task automatic model_edge();
    bit hz, br;
    if (!Mem_ready) return;
    hz = m_hz();
    br = (EX_JumpOP != 2'b00);
    for (int r = 0; r < 32; r++) if (pend[r] > 0) pend[r]--;
    if (EX_MemtoReg && EX_RegWrite && EX_WR_out != 5'd0) pend[EX_WR_out] = LL;
    if (br) flush_left = BF - 1;
    else if (flush_left > 0) flush_left--;
    if (hz && !br && exp_stall < 65535) exp_stall++;
  endtask

  task automatic clear_counts();
    n_pc_low = 0; n_if_fl = 0; n_id_fl = 0; n_br_fl = 0; n_lw = 0;
  endtask

  // driver: one cycle with the given inputs, outputs checked mid-cycle
  task automatic drive(input int rs, input int rt, input bit rsu, input bit rtu,
                       input int wr, input bit mtr, input bit rw,
                       input int jop, input bit mr);
    logic [5:0] e;
    @(negedge clk);
    ID_Rs = rs[4:0]; ID_Rt = rt[4:0]; ID_RsUse = rsu; ID_RtUse = rtu;
    EX_WR_out = wr[4:0]; EX_MemtoReg = mtr; EX_RegWrite = rw;
    EX_JumpOP = jop[1:0]; Mem_ready = mr;
    #1;
    exp_q.push_back(m_outs());
    e = exp_q.pop_front();
    check("outs", w_outs, e);
    if (!PCWrite)     n_pc_low++;
    if (IF_Flush)     n_if_fl++;
    if (ID_Flush)     n_id_fl++;
    if (Branch_Flush) n_br_fl++;
    if (Load_wait)    n_lw++;
    @(posedge clk);
    model_edge();
    #1;
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic set_idle();
    ID_Rs = '0; ID_Rt = '0; ID_RsUse = 0; ID_RtUse = 0;
    EX_WR_out = '0; EX_MemtoReg = 0; EX_RegWrite = 0;
    EX_JumpOP = '0; Mem_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    #1;
    check("rst_outs", w_outs, 6'b110000);
    check("rst_stall", stall_cnt, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    set_idle();
    model_clear();
    do_reset();

    // reset release with no activity
    idle(2);
    check("idle_pcwrite", PCWrite, 1);
    check("idle_stall", stall_cnt, 0);

    // lw $5 then ID reads $5: 3 stall cycles
    clear_counts();
    drive(5, 0, 1, 0, 5, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(5, 0, 1, 0, 0, 0, 0, 0, 1);
    check("lw_stall_cycles", n_pc_low, 3);
    check("lw_bubbles", n_id_fl, 3);
    check("lw_stall_cnt", stall_cnt, 3);
    check("lw_released", PCWrite, 1);

    // unused sources and $0 loads never stall
    do_reset();
    clear_counts();
    drive(5, 5, 0, 0, 5, 1, 1, 0, 1);
    drive(5, 5, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1);
    check("no_use_no_stall", n_pc_low, 0);
    idle(3);

    // taken branch with BR_FLUSH=3
    clear_counts();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    check("br_if_flush", n_if_fl, 3);
    check("br_id_flush", n_id_fl, 1);
    check("br_pulse", n_br_fl, 1);
    check("br_pcwrite", n_pc_low, 0);

    // pending load on $7 frozen by 4 memory-wait cycles
    clear_counts();
    drive(7, 0, 1, 0, 7, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(7, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(7, 0, 1, 0, 0, 0, 0, 0, 1);
    check("mw_load_wait", n_lw, 4);
    check("mw_pc_low", n_pc_low, 7);
    check("mw_released", PCWrite, 1);

    // reset mid-stall with a live entry
    drive(0, 9, 0, 1, 9, 1, 1, 0, 1);
    drive(0, 9, 0, 1, 0, 0, 0, 0, 1);
    check("pre_rst_stalled", PCWrite, 0);
    @(negedge clk);
    ID_Rt = 5'd9; ID_RtUse = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_outs", w_outs, 6'b110000);
    check("mid_rst_stall", stall_cnt, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    drive(0, 9, 0, 1, 0, 0, 0, 0, 1);
    check("post_rst_empty", n_pc_low, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
